sr_drive_ctrl: RTL and testbench
================================

// Module: sr_drive_ctrl
// PURPOSE
//   Upstream driver stage for the gated-NAND SR flip-flop. Accepts set/clear commands
//   over a valid/ready handshake and generates clean S/R pulses: never S=R=1, with a fixed
//   width and a settle gap. It reads back Q/Qn, checks the result, retries on mismatch and
//   reports DONE or ERR. It sits between control logic and the SR_Flip_Flop instance.
// PARAMETERS
//   PULSE_CYCLES   2   cycles S (or R) is held high per attempt; legal range 1..2**CNT_W-1
//   SETTLE_CYCLES  2   cycles with S=R=0 after a pulse, before readback; legal range 1..2**CNT_W-1
//   MAX_RETRY      3   extra attempts after the first failure; 0 = no retry
//   CNT_W          4   width of the internal pulse/settle counter
// PORTS
//   CLK        in   1        clock; all logic updates on the rising edge
//   RST        in   1        synchronous, active-high reset
//   CMD_VALID  in   1        command present
//   CMD_OP     in   1        1 = set (Q->1), 0 = clear (Q->0); sampled on accept
//   CMD_READY  out  1        controller idle and able to accept
//   S          out  1        set drive to the flip-flop, registered
//   R          out  1        reset drive to the flip-flop, registered
//   Q_FB       in   1        flip-flop Q readback
//   QN_FB      in   1        flip-flop Qn readback
//   BUSY       out  1        high in any state other than IDLE
//   DONE       out  1        1-cycle pulse: readback matched the command
//   ERR        out  1        1-cycle pulse: retries exhausted without a match
//   ERR_STICKY out  1        set together with ERR; cleared by RST or the next accepted command
// BEHAVIOUR
//   Reset: state=IDLE; S=R=BUSY=DONE=ERR=ERR_STICKY=0; retry count=0. Reset has priority
//     over everything. Reset mid-pulse forces S=R=0 at the next edge.
//   Output rules
//     - CMD_READY = (state==IDLE), combinational.
//     - Accept = CMD_VALID & CMD_READY at a rising edge. On accept, CMD_OP is latched into op_q.
//   States: IDLE -> PULSE -> SETTLE -> CHECK -> {IDLE | PULSE}
//     IDLE:   on accept go to PULSE, load counter=PULSE_CYCLES, clear retry and ERR_STICKY.
//     PULSE:  S=op_q, R=~op_q for exactly PULSE_CYCLES cycles. Then go to SETTLE and load
//             counter=SETTLE_CYCLES.
//     SETTLE: S=R=0 for exactly SETTLE_CYCLES cycles, then go to CHECK.
//     CHECK:  one cycle; S=R=0. Pass = (Q_FB==op_q) && (QN_FB==~op_q).
//             Q_FB==QN_FB (invalid flip-flop state) counts as a fail.
//       pass                    -> DONE=1 for one cycle, go to IDLE
//       fail, retry<MAX_RETRY   -> retry++, go to PULSE (reload counter)
//       fail, retry==MAX_RETRY  -> ERR=1 and ERR_STICKY=1, go to IDLE
//   Latency: accept at edge k -> S/R high during cycles k..k+PULSE_CYCLES-1 (edges) ->
//     DONE high after edge k+PULSE_CYCLES+SETTLE_CYCLES+1; CMD_READY is high in that same
//     cycle. Defaults give 5 cycles from accept to DONE. Each retry adds PULSE+SETTLE+1 cycles.
//   Invariant: S&R == 0 in every cycle, including reset and state transitions.
//   CMD_VALID while BUSY is ignored: no queueing, no error.
//   DONE and ERR are mutually exclusive and never high while BUSY.
//   The counter is 0-based with no wrap. It never underflows: the state changes when it hits 1.
// STRUCTURE
//   Shared package sr_pkg: state encoding (IDLE, PULSE, SETTLE, CHECK, 2 bits), op constants
//     OP_SET=1 and OP_CLR=0, and default timing constants.
//   Sub-module sr_pulse_timer: loadable down-counter (CNT_W) with a load input and an
//     expire output. Used for both PULSE and SETTLE.
//   Top level: FSM, op_q/retry registers, registered S/R/DONE/ERR.
// TESTING  (bench instantiates sr_drive_ctrl -> SR_Flip_Flop, with feedback closed)
//   1. RST 2 cycles, then set (OP=1) -> S high exactly 2 cycles, R=0; DONE 5 cycles after
//      accept; Q=1, Qn=0.
//   2. Clear after set (OP=0) -> R high 2 cycles, DONE after 5 cycles, Q=0. Assert S&R==0
//      every cycle.
//   3. Feedback forced stuck at Q_FB=0 with OP=1 and MAX_RETRY=3 -> 4 pulses total; ERR at
//      cycle 20 after accept; ERR_STICKY=1 until the next accept.
//   4. Fail once, then release the force -> one retry; DONE at cycle 10 after accept;
//      ERR never asserts.
//   5. RST asserted during the 2nd PULSE cycle -> S=0 the next cycle; CMD_READY=1 after
//      reset; no DONE/ERR.
//   6. CMD_VALID held high through BUSY with alternating OP -> only the first command is
//      executed; the next is accepted in the DONE cycle.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop drive controller.
package sr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } sr_state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  localparam int DEF_PULSE_CYCLES  = 2;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_MAX_RETRY     = 3;
  localparam int DEF_CNT_W         = 4;

  // Readback is good only when Q matches the command and Qn is its complement;
  // Q==Qn (both rails equal) is never a pass.
  function automatic logic fb_match(input logic op, input logic q, input logic qn);
    return (q == op) && (qn == ~op);
  endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter shared by the pulse and settle phases.
// expire is high while the count sits at 1; the count parks at 0 and never wraps.
module sr_pulse_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/sr_drive_ctrl.sv
// Drive controller for the gated-NAND SR flip-flop: pulses S or R for a fixed
// width, waits a settle gap, checks Q/Qn readback and retries on mismatch.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ready for a command, S=R=0
// ST_PULSE  | driving S=op_q / R=~op_q for PULSE_CYCLES
// ST_SETTLE | S=R=0 for SETTLE_CYCLES so the flip-flop output can settle
// ST_CHECK  | one cycle readback compare: DONE, retry, or ERR
module sr_drive_ctrl
  import sr_pkg::*;
#(
  parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int MAX_RETRY     = DEF_MAX_RETRY,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic CLK,
  input  logic RST,
  input  logic CMD_VALID,
  input  logic CMD_OP,
  output logic CMD_READY,
  output logic S,
  output logic R,
  input  logic Q_FB,
  input  logic QN_FB,
  output logic BUSY,
  output logic DONE,
  output logic ERR,
  output logic ERR_STICKY
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0]    RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  sr_state_t        state;
  logic             op_q;
  logic [RW-1:0]    retry;
  logic             accept;
  logic             fb_pass;
  logic             retry_left;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_exp;

  assign CMD_READY  = (state == ST_IDLE);
  assign BUSY       = (state != ST_IDLE);
  assign accept     = CMD_VALID && CMD_READY;
  assign fb_pass    = fb_match(op_q, Q_FB, QN_FB);
  assign retry_left = (retry < RETRY_LIM);

  // Timer reloads on accept, on pulse->settle, and on a retry back into pulse.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = PULSE_LD;
    case (state)
      ST_IDLE:  tmr_load = accept;
      ST_PULSE: begin
        tmr_load = tmr_exp;
        tmr_val  = SETTLE_LD;
      end
      ST_CHECK: tmr_load = !fb_pass && retry_left;
      default:  tmr_load = 1'b0;
    endcase
  end

  sr_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_exp)
  );

  // Sequencer with registered drives; S and R are only ever set as complements
  // of op_q in PULSE, so they can never be high together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      op_q       <= OP_CLR;
      retry      <= '0;
      S          <= 1'b0;
      R          <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      ERR_STICKY <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_PULSE;
            op_q       <= CMD_OP;
            retry      <= '0;
            ERR_STICKY <= 1'b0;
            S          <= CMD_OP;
            R          <= ~CMD_OP;
          end
        end
        ST_PULSE: begin
          if (tmr_exp) begin
            state <= ST_SETTLE;
            S     <= 1'b0;
            R     <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (tmr_exp) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (fb_pass) begin
            DONE  <= 1'b1;
            state <= ST_IDLE;
          end else if (retry_left) begin
            retry <= retry + RW'(1);
            state <= ST_PULSE;
            S     <= op_q;
            R     <= ~op_q;
          end else begin
            ERR        <= 1'b1;
            ERR_STICKY <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          S     <= 1'b0;
          R     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl with a behavioural SR flip-flop closing the
// feedback loop. Sample index j means "after edge k+j" where k is the accept edge.
module tb_sr_drive_ctrl;
  import sr_pkg::*;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_op, cmd_ready, s, r, q_fb, qn_fb, busy, done, err, err_sticky;
  logic q_ff = 1'b0;
  logic stuck = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;
  int bad_flag = 0;

  always #5 clk = ~clk;

  sr_drive_ctrl dut (
    .CLK        (clk),
    .RST        (rst),
    .CMD_VALID  (cmd_valid),
    .CMD_OP     (cmd_op),
    .CMD_READY  (cmd_ready),
    .S          (s),
    .R          (r),
    .Q_FB       (q_fb),
    .QN_FB      (qn_fb),
    .BUSY       (busy),
    .DONE       (done),
    .ERR        (err),
    .ERR_STICKY (err_sticky)
  );

  // Flip-flop model: set/reset on the edge, hold when S=R=0.
  always @(posedge clk) begin
    if (s) q_ff <= 1'b1;
    else if (r) q_ff <= 1'b0;
  end
  assign q_fb  = stuck ? 1'b0 : q_ff;
  assign qn_fb = ~q_ff;

  // Every-cycle invariants, tallied and checked at the end.
  always @(negedge clk) begin
    if (s && r) overlap++;
    if ((done || err) && busy) bad_flag++;
    if (done && err) bad_flag++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic op);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk);
  endtask

  task automatic run(input int limit, input int release_at,
                     output int done_at, output int err_at,
                     output int s_cnt, output int r_cnt, output int sticky0);
    done_at = -1; err_at = -1; s_cnt = 0; r_cnt = 0; sticky0 = -1;
    for (int j = 0; j < limit; j++) begin
      @(negedge clk);
      if (j == 0) begin
        cmd_valid = 1'b0;
        sticky0   = {31'd0, err_sticky};
      end
      if (s) s_cnt++;
      if (r) r_cnt++;
      if (j == release_at) stuck = 1'b0;
      if (done) begin done_at = j; break; end
      if (err)  begin err_at  = j; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, e, sc, rc, st0, cnt;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s", {31'd0, s}, 0);
    chk("rst_r", {31'd0, r}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_sticky", {31'd0, err_sticky}, 0);
    chk("rst_ready", {31'd0, cmd_ready}, 1);
    rst = 1'b0;

    // 1: set
    issue(OP_SET);
    run(30, -1, d, e, sc, rc, st0);
    chk("t1_s_cnt", sc, 2);
    chk("t1_r_cnt", rc, 0);
    chk("t1_done_at", d, 5);
    chk("t1_err_at", e, -1);
    chk("t1_ready", {31'd0, cmd_ready}, 1);
    chk("t1_q", {31'd0, q_fb}, 1);
    chk("t1_qn", {31'd0, qn_fb}, 0);

    // 2: clear
    issue(OP_CLR);
    run(30, -1, d, e, sc, rc, st0);
    chk("t2_r_cnt", rc, 2);
    chk("t2_s_cnt", sc, 0);
    chk("t2_done_at", d, 5);
    chk("t2_q", {31'd0, q_fb}, 0);

    // 3: Q_FB stuck low, four attempts then ERR
    stuck = 1'b1;
    issue(OP_SET);
    run(40, -1, d, e, sc, rc, st0);
    chk("t3_s_cnt", sc, 8);
    chk("t3_r_cnt", rc, 0);
    chk("t3_err_at", e, 20);
    chk("t3_done_at", d, -1);
    chk("t3_sticky", {31'd0, err_sticky}, 1);
    repeat (3) @(negedge clk);
    chk("t3_sticky_hold", {31'd0, err_sticky}, 1);

    // 4: fail once, release after the first check -> one retry
    issue(OP_SET);
    run(40, 5, d, e, sc, rc, st0);
    chk("t4_sticky_clr", st0, 0);
    chk("t4_done_at", d, 10);
    chk("t4_err_at", e, -1);
    chk("t4_s_cnt", sc, 4);
    stuck = 1'b0;

    // 5: reset during the second pulse cycle
    issue(OP_SET);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t5_s_first", {31'd0, s}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_s_after", {31'd0, s}, 0);
    chk("t5_r_after", {31'd0, r}, 0);
    chk("t5_ready", {31'd0, cmd_ready}, 1);
    chk("t5_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || err) cnt++;
    end
    chk("t5_no_result", cnt, 0);

    // 6: valid held with toggling op; first command is clear
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_CLR;
    @(posedge clk);
    sc = 0; rc = 0; d = -1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (s) sc++;
      if (r) rc++;
      if (done) begin
        d = j;
        chk("t6_ready_in_done", {31'd0, cmd_ready}, 1);
      end
      cmd_op = ~cmd_op;
      if (done) break;
    end
    chk("t6_done_at", d, 5);
    chk("t6_s_cnt", sc, 0);
    chk("t6_r_cnt", rc, 2);
    // op was back to clear at the DONE edge, so the second command is a clear
    @(negedge clk);
    chk("t6_busy2", {31'd0, busy}, 1);
    chk("t6_r2", {31'd0, r}, 1);
    chk("t6_s2", {31'd0, s}, 0);
    cmd_valid = 1'b0;
    // run() starts one sample late here, so DONE lands at its index 4
    run(30, -1, d, e, sc, rc, st0);
    chk("t6_done2_at", d, 4);
    chk("t6_q", {31'd0, q_fb}, 0);

    // Invariants over the whole run
    chk("inv_s_and_r", overlap, 0);
    chk("inv_done_err_busy", bad_flag, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
